// File: rtl/spi_sb_xfer.sv
`default_nettype none
// ============================================================================
// Module   : spi_sb_xfer
// Purpose  : Drives a SPI hard block over its system bus: init, then
//            streams bytes out and returns received bytes per frame.
// Revision : 1.0
// ============================================================================
module spi_sb_xfer #(
    parameter logic [3:0] BUS_ADDR74  = 4'b0000,
    parameter logic [5:0] SPI_BR      = 6'd2,
    parameter logic [3:0] CS_MASK     = 4'b0001,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       err,
    output logic       sb_stb,
    output logic       sb_rw,
    output logic [7:0] sb_adr,
    output logic [7:0] sb_dat_o,
    input  logic [7:0] sb_dat_i,
    input  logic       sb_ack
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] c_TMO_LAST = CW'(ACK_TIMEOUT - 1);

    localparam logic [3:0] c_OFF_CR1  = 4'h9;
    localparam logic [3:0] c_OFF_CR2  = 4'hA;
    localparam logic [3:0] c_OFF_BR   = 4'hB;
    localparam logic [3:0] c_OFF_SR   = 4'hC;
    localparam logic [3:0] c_OFF_TXDR = 4'hD;
    localparam logic [3:0] c_OFF_RXDR = 4'hE;
    localparam logic [3:0] c_OFF_CSR  = 4'hF;

    typedef enum logic [3:0] {
        INIT_CR1 = 4'd0,
        INIT_CR2 = 4'd1,
        INIT_BR  = 4'd2,
        IDLE     = 4'd3,
        CS_ON    = 4'd4,
        POLL_T   = 4'd5,
        WR_TX    = 4'd6,
        POLL_R   = 4'd7,
        RD_RX    = 4'd8,
        CS_OFF   = 4'd9
    } state_t;

    state_t          state_q, state_d;
    logic            stb_q, stb_d;
    logic            rw_q, rw_d;
    logic [7:0]      adr_q, adr_d;
    logic [7:0]      dat_q, dat_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            last_q, last_d;
    logic            pend_q, pend_d;
    logic            trdy_q, trdy_d;
    logic            rxv_q, rxv_d;
    logic [7:0]      rxd_q, rxd_d;
    logic            err_q, err_d;

    logic            w_acc_en;
    logic            w_acc_rw;
    logic [3:0]      w_acc_off;
    logic [7:0]      w_acc_wdat;
    logic            w_done;
    state_t          w_tmo_state;

    // Bus access that the current state wants to perform.
    always_comb begin
        w_acc_en   = 1'b1;
        w_acc_rw   = 1'b0;
        w_acc_off  = c_OFF_SR;
        w_acc_wdat = 8'h00;
        case (state_q)
            INIT_CR1: begin w_acc_rw = 1'b1; w_acc_off = c_OFF_CR1;  w_acc_wdat = 8'h80; end
            INIT_CR2: begin w_acc_rw = 1'b1; w_acc_off = c_OFF_CR2;  w_acc_wdat = 8'hC0; end
            INIT_BR:  begin w_acc_rw = 1'b1; w_acc_off = c_OFF_BR;   w_acc_wdat = {2'b00, SPI_BR}; end
            IDLE:     w_acc_en = 1'b0;
            CS_ON:    begin w_acc_rw = 1'b1; w_acc_off = c_OFF_CSR;  w_acc_wdat = {4'b0000, CS_MASK}; end
            POLL_T:   w_acc_en = !trdy_q;
            WR_TX:    begin w_acc_rw = 1'b1; w_acc_off = c_OFF_TXDR; w_acc_wdat = byte_q; end
            POLL_R:   w_acc_off = c_OFF_SR;
            RD_RX:    w_acc_off = c_OFF_RXDR;
            CS_OFF:   begin w_acc_rw = 1'b1; w_acc_off = c_OFF_CSR;  w_acc_wdat = 8'h00; end
            default:  w_acc_en = 1'b0;
        endcase
    end

    always_comb begin
        case (state_q)
            INIT_CR1, INIT_CR2, INIT_BR: w_tmo_state = INIT_CR1;
            CS_OFF:                      w_tmo_state = IDLE;
            default:                     w_tmo_state = CS_OFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        rw_d    = rw_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        last_d  = last_q;
        pend_d  = pend_q;
        trdy_d  = trdy_q;
        rxv_d   = 1'b0;
        rxd_d   = rxd_q;
        err_d   = 1'b0;
        w_done  = 1'b0;

        // Strobe only rises from low, so every access is preceded by an idle cycle.
        if (w_acc_en) begin
            if (!stb_q) begin
                stb_d = 1'b1;
                rw_d  = w_acc_rw;
                adr_d = {BUS_ADDR74, w_acc_off};
                dat_d = w_acc_wdat;
                cnt_d = '0;
            end else if (sb_ack) begin
                stb_d  = 1'b0;
                w_done = 1'b1;
            end else if (cnt_q == c_TMO_LAST) begin
                stb_d   = 1'b0;
                err_d   = 1'b1;
                pend_d  = 1'b0;
                trdy_d  = 1'b0;
                state_d = w_tmo_state;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        case (state_q)
            INIT_CR1: if (w_done) state_d = INIT_CR2;
            INIT_CR2: if (w_done) state_d = INIT_BR;
            INIT_BR:  if (w_done) state_d = IDLE;
            IDLE: begin
                if (tx_valid) begin
                    byte_d  = tx_data;
                    last_d  = tx_last;
                    pend_d  = 1'b1;
                    trdy_d  = 1'b0;
                    state_d = CS_ON;
                end
            end
            CS_ON: if (w_done) state_d = POLL_T;
            POLL_T: begin
                // Later bytes of a frame: poll TRDY first, then park with tx_ready high.
                if (w_done && sb_dat_i[4]) begin
                    if (pend_q) state_d = WR_TX;
                    else        trdy_d  = 1'b1;
                end else if (trdy_q && tx_valid) begin
                    byte_d  = tx_data;
                    last_d  = tx_last;
                    trdy_d  = 1'b0;
                    state_d = WR_TX;
                end
            end
            WR_TX: begin
                if (w_done) begin
                    pend_d  = 1'b0;
                    state_d = POLL_R;
                end
            end
            POLL_R: if (w_done && sb_dat_i[3]) state_d = RD_RX;
            RD_RX: begin
                if (w_done) begin
                    rxv_d   = 1'b1;
                    rxd_d   = sb_dat_i;
                    state_d = last_q ? CS_OFF : POLL_T;
                end
            end
            CS_OFF: if (w_done) state_d = IDLE;
            default: state_d = INIT_CR1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT_CR1;
            stb_q   <= 1'b0;
            rw_q    <= 1'b0;
            adr_q   <= 8'h00;
            dat_q   <= 8'h00;
            cnt_q   <= '0;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            trdy_q  <= 1'b0;
            rxv_q   <= 1'b0;
            rxd_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            rw_q    <= rw_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            trdy_q  <= trdy_d;
            rxv_q   <= rxv_d;
            rxd_q   <= rxd_d;
            err_q   <= err_d;
        end
    end

    assign tx_ready = (state_q == IDLE) || ((state_q == POLL_T) && trdy_q);
    assign busy     = (state_q != IDLE);
    assign rx_valid = rxv_q;
    assign rx_data  = rxd_q;
    assign err      = err_q;
    assign sb_stb   = stb_q;
    assign sb_rw    = rw_q;
    assign sb_adr   = adr_q;
    assign sb_dat_o = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_sb_xfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sb_xfer
// Purpose  : Scoreboard bench for spi_sb_xfer with a reactive bus model.
// Revision : 1.0
// ============================================================================
module tb_spi_sb_xfer;

    localparam logic [3:0] A74 = 4'h0;
    localparam logic [5:0] BR  = 6'd2;
    localparam logic [3:0] CSM = 4'h1;
    localparam int         TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid, tx_ready, tx_last;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy, err;
    logic       sb_stb, sb_rw, sb_ack;
    logic [7:0] sb_adr, sb_dat_o, sb_dat_i;

    always #5 clk = ~clk;

    spi_sb_xfer #(
        .BUS_ADDR74(A74), .SPI_BR(BR), .CS_MASK(CSM), .ACK_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .err(err),
        .sb_stb(sb_stb), .sb_rw(sb_rw), .sb_adr(sb_adr), .sb_dat_o(sb_dat_o),
        .sb_dat_i(sb_dat_i), .sb_ack(sb_ack)
    );

    int total = 0;
    int bad   = 0;

    logic [16:0] exp_bus[$];   // {rw, adr, wdata-or-0}
    logic [7:0]  exp_rx[$];
    logic [7:0]  sr_q[$];      // SPISR responses in order
    logic [7:0]  rxd_q[$];     // SPIRXDR responses in order
    logic [7:0]  bq[$];

    int lat_lo = 1, lat_hi = 1;
    bit spur = 0, allow_extra = 0, noack_tx = 0;
    int err_seen = 0;

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [16:0] wr(input logic [3:0] off, input logic [7:0] d);
        return {1'b1, A74, off, d};
    endfunction

    function automatic logic [16:0] rd(input logic [3:0] off);
        return {1'b0, A74, off, 8'h00};
    endfunction

    function automatic logic [7:0] resp(input logic [3:0] off);
        if (off == 4'hC) return (sr_q.size() != 0) ? sr_q.pop_front() : (8'($urandom) & 8'hE7);
        if (off == 4'hE) return (rxd_q.size() != 0) ? rxd_q.pop_front() : 8'($urandom);
        return 8'($urandom);
    endfunction

    task automatic score(input logic [16:0] act);
        logic [16:0] e;
        if (exp_bus.size() == 0 && allow_extra && act[16:8] == {1'b0, A74, 4'hC}) return;
        check(exp_bus.size() != 0, "bus_extra_txn", 32'(act), 0);
        if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            check(act == e, "bus_txn", 32'(act), 32'(e));
        end
    endtask

    // Bus slave model: acks after a random latency, logs every access.
    logic        prev_stb = 0, prev_acked = 0;
    int          cyc = 0, lat = 1;
    logic [16:0] cur = '0;
    always @(negedge clk) begin
        if (rst) begin
            sb_ack = 1'b0; prev_stb = 1'b0; prev_acked = 1'b0; cyc = 0;
        end else begin
            if (prev_acked) check(!sb_stb, "stb_gap", 32'(sb_stb), 0);
            if (sb_stb) begin
                if (!prev_stb) begin
                    cyc = 0;
                    lat = int'($urandom_range(lat_hi, lat_lo));
                    cur = {sb_rw, sb_adr, sb_rw ? sb_dat_o : 8'h00};
                end else begin
                    check(cur == {sb_rw, sb_adr, sb_rw ? sb_dat_o : 8'h00}, "bus_stable",
                          32'({sb_rw, sb_adr, sb_dat_o}), 32'(cur));
                end
                cyc++;
                if (cyc >= lat && !(noack_tx && sb_rw && sb_adr[3:0] == 4'hD)) begin
                    sb_ack   = 1'b1;
                    sb_dat_i = resp(sb_adr[3:0]);
                    score(cur);
                end else begin
                    sb_ack   = 1'b0;
                    sb_dat_i = 8'($urandom);
                end
            end else begin
                if (prev_stb && !prev_acked) begin
                    check(cyc == TMO, "ack_timeout_len", 32'(cyc), 32'(TMO));
                    score(cur);
                end
                sb_ack   = spur && ($urandom_range(3, 0) == 0);
                sb_dat_i = 8'($urandom);
            end
            prev_acked = sb_stb && sb_ack;
            prev_stb   = sb_stb;
        end
    end

    // Received-byte and error monitor.
    logic       prev_rxv = 0;
    logic [7:0] e8;
    always @(negedge clk) begin
        if (rx_valid) begin
            check(!prev_rxv, "rx_pulse_width", 1, 0);
            check(exp_rx.size() != 0, "rx_extra", 32'(rx_data), 0);
            if (exp_rx.size() != 0) begin
                e8 = exp_rx.pop_front();
                check(rx_data == e8, "rx_data", 32'(rx_data), 32'(e8));
            end
        end
        if (err) err_seen++;
        prev_rxv = rx_valid;
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        tx_valid = 1'b1; tx_data = d; tx_last = l;
        while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
        check(tx_ready == 1'b1, "send_accept", 32'(tx_ready), 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_bus.size() != 0 || exp_rx.size() != 0 || busy) && n < 4000) begin
            @(negedge clk); n++;
        end
        check(n < 4000, nm, 32'(n), 4000);
    endtask

    // Reference: a frame is CS on, per byte (TRDY polls, TX write, RRDY polls, RX read), CS off.
    task automatic frame(input int kt);
        logic [7:0] r;
        int k;
        exp_bus.push_back(wr(4'hF, {4'h0, CSM}));
        foreach (bq[i]) begin
            k = (kt >= 0) ? kt : int'($urandom_range(3, 0));
            repeat (k) begin sr_q.push_back(8'($urandom) & 8'hEF); exp_bus.push_back(rd(4'hC)); end
            sr_q.push_back(8'($urandom) | 8'h10); exp_bus.push_back(rd(4'hC));
            exp_bus.push_back(wr(4'hD, bq[i]));
            k = (kt >= 0) ? 0 : int'($urandom_range(3, 0));
            repeat (k) begin sr_q.push_back(8'($urandom) & 8'hF7); exp_bus.push_back(rd(4'hC)); end
            sr_q.push_back(8'($urandom) | 8'h08); exp_bus.push_back(rd(4'hC));
            r = 8'($urandom);
            rxd_q.push_back(r); exp_rx.push_back(r);
            exp_bus.push_back(rd(4'hE));
        end
        exp_bus.push_back(wr(4'hF, 8'h00));
        foreach (bq[i]) begin
            repeat ($urandom_range(4, 0)) @(negedge clk);
            send(bq[i], i == bq.size() - 1);
        end
        wait_idle("frame_done");
    endtask

    task automatic push_init();
        exp_bus.push_back(wr(4'h9, 8'h80));
        exp_bus.push_back(wr(4'hA, 8'hC0));
        exp_bus.push_back(wr(4'hB, {2'b00, BR}));
    endtask

    initial begin
        int n;
        int exp_err;
        logic [7:0] d;
        tx_valid = 0; tx_data = 0; tx_last = 0; sb_ack = 0; sb_dat_i = 0;
        repeat (3) @(negedge clk);
        check(sb_stb == 0,      "rst_stb",      32'(sb_stb), 0);
        check(sb_rw == 0,       "rst_rw",       32'(sb_rw), 0);
        check(sb_adr == 8'h00,  "rst_adr",      32'(sb_adr), 0);
        check(sb_dat_o == 8'h00,"rst_dat",      32'(sb_dat_o), 0);
        check(tx_ready == 0,    "rst_tx_ready", 32'(tx_ready), 0);
        check(rx_valid == 0,    "rst_rx_valid", 32'(rx_valid), 0);
        check(rx_data == 8'h00, "rst_rx_data",  32'(rx_data), 0);
        check(busy == 1,        "rst_busy",     32'(busy), 1);
        check(err == 0,         "rst_err",      32'(err), 0);

        push_init();
        rst = 1'b0;
        wait_idle("init_done");
        check(tx_ready == 1, "init_tx_ready", 32'(tx_ready), 1);

        // Single byte with fixed status and receive data.
        exp_bus.push_back(wr(4'hF, 8'h01));
        sr_q.push_back(8'h10); exp_bus.push_back(rd(4'hC));
        exp_bus.push_back(wr(4'hD, 8'hA5));
        sr_q.push_back(8'h08); exp_bus.push_back(rd(4'hC));
        rxd_q.push_back(8'h3C); exp_rx.push_back(8'h3C); exp_bus.push_back(rd(4'hE));
        exp_bus.push_back(wr(4'hF, 8'h00));
        send(8'hA5, 1'b1);
        wait_idle("single_done");

        bq = {8'h01, 8'h02, 8'h03};
        frame(-1);

        bq = {8'($urandom)};
        frame(5);

        spur = 1; lat_lo = 1; lat_hi = 4;
        for (int f = 0; f < 8; f++) begin
            bq = {};
            n = int'($urandom_range(4, 1));
            for (int b = 0; b < n; b++) bq.push_back(8'($urandom));
            frame(-1);
        end
        check(err_seen == 0, "no_err_normal", 32'(err_seen), 0);

        // TX write never acknowledged.
        spur = 0; lat_lo = 1; lat_hi = 2; noack_tx = 1;
        exp_err = err_seen + 1;
        d = 8'($urandom);
        exp_bus.push_back(wr(4'hF, {4'h0, CSM}));
        sr_q.push_back(8'h10); exp_bus.push_back(rd(4'hC));
        exp_bus.push_back(wr(4'hD, d));
        exp_bus.push_back(wr(4'hF, 8'h00));
        send(d, 1'b0);
        wait_idle("timeout_done");
        check(err_seen == exp_err, "timeout_err_count", 32'(err_seen), 32'(exp_err));
        check(tx_ready == 1, "timeout_idle", 32'(tx_ready), 1);
        noack_tx = 0;

        bq = {8'h55};
        frame(-1);

        // Reset while polling RRDY.
        lat_lo = 3; lat_hi = 3; allow_extra = 1;
        d = 8'($urandom);
        exp_bus.push_back(wr(4'hF, {4'h0, CSM}));
        sr_q.push_back(8'h10); exp_bus.push_back(rd(4'hC));
        exp_bus.push_back(wr(4'hD, d));
        send(d, 1'b1);
        n = 0;
        while (exp_bus.size() != 0 && n < 500) begin @(negedge clk); n++; end
        check(n < 500, "reach_poll_r", 32'(n), 500);
        repeat ($urandom_range(8, 2)) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check(sb_stb == 0,   "midrst_stb",      32'(sb_stb), 0);
        check(busy == 1,     "midrst_busy",     32'(busy), 1);
        check(rx_valid == 0, "midrst_rx_valid", 32'(rx_valid), 0);
        @(negedge clk);
        allow_extra = 0; lat_lo = 1; lat_hi = 1;
        push_init();
        rst = 1'b0;
        wait_idle("reinit_done");
        check(tx_ready == 1, "reinit_tx_ready", 32'(tx_ready), 1);
        check(err_seen == exp_err, "final_err_count", 32'(err_seen), 32'(exp_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: actual=expired required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
